// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared frame geometry and FSM state type for the SPI frame responder
package spi_pkg;

  localparam int FRAME_BITS_DEFAULT = 392;

  // Frame fields, MSB first on the wire: key, plaintext, header
  localparam int KEY_MSB = 391;
  localparam int KEY_LSB = 264;
  localparam int PT_MSB  = 263;
  localparam int PT_LSB  = 136;
  localparam int HDR_MSB = 135;
  localparam int HDR_LSB = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_t;

endpackage

// File: rtl/spi_frame_responder_if.sv
// rtl/spi_frame_responder_if.sv - SPI pins plus rx/tx handshake bundle for the frame responder
interface spi_frame_responder_if
  import spi_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEFAULT
);

  logic                  sclk;
  logic                  cs;
  logic                  mosi;
  logic                  miso;
  logic [FRAME_BITS-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [FRAME_BITS-1:0] tx_data;
  logic                  tx_load;
  logic                  busy;
  logic                  done;
  logic                  frame_err;
  logic                  overrun;

  modport slave (
    input  sclk, cs, mosi, rx_ready, tx_data, tx_load,
    output miso, rx_data, rx_valid, busy, done, frame_err, overrun
  );

  modport master (
    output sclk, cs, mosi, rx_ready, tx_data, tx_load,
    input  miso, rx_data, rx_valid, busy, done, frame_err, overrun
  );

endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with rise/fall pulses on the synced level
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Resetting to 0 means a cs already low at reset release yields no fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_frame_responder.sv
// rtl/spi_frame_responder.sv - SPI mode-0 slave that receives a fixed-length frame and returns tx_buf
module spi_frame_responder
  import spi_pkg::*;
#(
  parameter int FRAME_BITS  = FRAME_BITS_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  spi_frame_responder_if.slave  bus
);

  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_BITS - 1);

  spi_state_t            r_state;
  spi_state_t            w_state_next;
  logic [FRAME_BITS-1:0] r_tx_buf;
  logic [FRAME_BITS-1:0] r_tx_shift;
  logic [FRAME_BITS-1:0] r_rx_shift;
  logic [FRAME_BITS-1:0] r_rx_data;
  logic [CW-1:0]         r_bit_cnt;
  logic                  r_miso;
  logic                  r_rx_valid;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_frame_err;
  logic                  r_overrun;
  logic [SYNC_STAGES-1:0] r_mosi_sync;

  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_start, w_sample, w_shift_out, w_stop;
  logic w_complete, w_accept, w_mosi_s;
  logic w_unused;
  logic [FRAME_BITS-1:0] w_frame;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk    (clk),
    .reset  (reset),
    .i_async(bus.sclk),
    .o_level(w_sclk_lvl),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk    (clk),
    .reset  (reset),
    .i_async(bus.cs),
    .o_level(w_cs_lvl),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  // mosi shares the sclk sync depth so data and clock stay aligned
  always_ff @(posedge clk) begin
    if (reset) r_mosi_sync <= '0;
    else       r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
  end

  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
  assign w_unused = &{1'b0, w_sclk_lvl, w_cs_lvl};

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_sample     = 1'b0;
    w_shift_out  = 1'b0;
    w_stop       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_start      = 1'b1;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (w_cs_rise) begin
          w_stop       = 1'b1;
          w_state_next = IDLE;
        end else if (r_bit_cnt < CNT_FULL) begin
          w_sample    = w_sclk_rise;
          w_shift_out = w_sclk_fall;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_complete = w_sample && (r_bit_cnt == CNT_LAST);
  assign w_accept   = r_rx_valid && bus.rx_ready;
  assign w_frame    = {r_rx_shift[FRAME_BITS-2:0], w_mosi_s};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_buf    <= '0;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_rx_data   <= '0;
      r_bit_cnt   <= '0;
      r_miso      <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_done      <= w_complete;
      r_overrun   <= w_complete && r_rx_valid && !w_accept;
      r_frame_err <= w_stop && (r_bit_cnt != '0) && (r_bit_cnt < CNT_FULL);

      if (bus.tx_load) r_tx_buf <= bus.tx_data;

      // A completing frame wins over a same-cycle acceptance
      if (w_complete) begin
        r_rx_data  <= w_frame;
        r_rx_valid <= 1'b1;
      end else if (w_accept) begin
        r_rx_valid <= 1'b0;
      end

      if (w_start) begin
        r_tx_shift <= r_tx_buf;
        r_miso     <= r_tx_buf[FRAME_BITS-1];
        r_bit_cnt  <= '0;
        r_busy     <= 1'b1;
      end
      if (w_sample) begin
        r_rx_shift <= w_frame;
        r_bit_cnt  <= r_bit_cnt + 1'b1;
      end
      if (w_shift_out) begin
        r_tx_shift <= {r_tx_shift[FRAME_BITS-2:0], 1'b0};
        r_miso     <= r_tx_shift[FRAME_BITS-2];
      end
      if (w_stop) begin
        r_busy <= 1'b0;
        r_miso <= 1'b0;
      end
    end
  end

  assign bus.miso      = r_miso;
  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.frame_err = r_frame_err;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_spi_frame_responder.sv
// tb/tb_spi_frame_responder.sv - randomized SPI master driving the responder against a frame-level model
module tb_spi_frame_responder;
  import spi_pkg::*;

  localparam int FB = FRAME_BITS_DEFAULT;
  localparam int H  = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_frame_responder_if #(.FRAME_BITS(FB)) bus ();

  spi_frame_responder #(.FRAME_BITS(FB), .SYNC_STAGES(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int err_seen = 0;
  int ovr_seen = 0;

  logic [FB-1:0] m_tx_buf;
  logic [FB-1:0] m_rx_data;
  logic          m_rx_valid;
  int            m_done, m_err, m_ovr;

  // Pulse outputs are counted per high cycle, so a stretched pulse shows up as an extra count
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.done)      done_seen++;
      if (bus.frame_err) err_seen++;
      if (bus.overrun)   ovr_seen++;
    end
  end

  task automatic check(input string tag, input logic [FB-1:0] got, input logic [FB-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [FB-1:0] rand_frame();
    logic [FB-1:0] r;
    r = '0;
    for (int k = 0; k < FB; k += 32) r = {r[FB-33:0], 32'($urandom)};
    return r;
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_rx_data"},  bus.rx_data, m_rx_data);
    check({tag, "_rx_valid"}, FB'(bus.rx_valid), FB'(m_rx_valid));
    check({tag, "_done"},     FB'(done_seen), FB'(m_done));
    check({tag, "_ferr"},     FB'(err_seen), FB'(m_err));
    check({tag, "_ovr"},      FB'(ovr_seen), FB'(m_ovr));
    check({tag, "_busy"},     FB'(bus.busy), FB'(0));
    check({tag, "_miso_idle"}, FB'(bus.miso), FB'(0));
  endtask

  task automatic load_tx(input logic [FB-1:0] v);
    bus.tx_data = v;
    bus.tx_load = 1'b1;
    tick(1);
    bus.tx_load = 1'b0;
    m_tx_buf = v;
  endtask

  task automatic accept();
    bus.rx_ready = 1'b1;
    tick(1);
    bus.rx_ready = 1'b0;
    m_rx_valid = 1'b0;
    check("accept_rx_valid", FB'(bus.rx_valid), FB'(0));
  endtask

  // One master transaction of nbits clocks; optional tx_load or reset before bit load_at / reset_at
  task automatic xfer(input string tag, input logic [FB-1:0] dout, input int nbits,
                      input int load_at, input logic [FB-1:0] load_val, input int reset_at);
    logic [FB-1:0] exp_tx;
    logic [FB-1:0] din;
    bit aborted;
    exp_tx  = m_tx_buf;
    din     = '0;
    aborted = 1'b0;
    bus.cs   = 1'b0;
    bus.mosi = dout[FB-1];
    tick(H);
    if (reset_at < 0) check({tag, "_busy_mid"}, FB'(bus.busy), FB'(1));
    for (int i = 0; i < nbits; i++) begin
      if (i == reset_at) begin
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        aborted    = 1'b1;
        m_rx_valid = 1'b0;
        m_rx_data  = '0;
        m_tx_buf   = '0;
        tick(1);
        check({tag, "_miso_rst"}, FB'(bus.miso), FB'(0));
        check({tag, "_valid_rst"}, FB'(bus.rx_valid), FB'(0));
      end
      if (i == load_at) begin
        bus.tx_data = load_val;
        bus.tx_load = 1'b1;
        tick(1);
        bus.tx_load = 1'b0;
        m_tx_buf = load_val;
      end
      bus.sclk = 1'b1;
      din = {din[FB-2:0], bus.miso};
      tick(H);
      bus.sclk = 1'b0;
      if (i + 1 < FB) begin
        int idx;
        idx = FB - 2 - i;
        bus.mosi = dout[idx];
      end
      tick(H);
    end
    bus.cs = 1'b1;
    tick(2 * H);
    if (!aborted) begin
      if (nbits == FB) begin
        if (m_rx_valid) m_ovr++;
        m_rx_data  = dout;
        m_rx_valid = 1'b1;
        m_done++;
        check({tag, "_miso_frame"}, din, exp_tx);
      end else if (nbits > 0) begin
        m_err++;
      end
    end
    check_state(tag);
  endtask

  initial begin
    logic [FB-1:0] fa, fb;
    bus.sclk = 1'b0; bus.cs = 1'b1; bus.mosi = 1'b0;
    bus.rx_ready = 1'b0; bus.tx_data = '0; bus.tx_load = 1'b0;
    reset = 1'b1;
    m_tx_buf = '0; m_rx_data = '0; m_rx_valid = 1'b0;
    m_done = 0; m_err = 0; m_ovr = 0;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_miso",      FB'(bus.miso), FB'(0));
    check("rst_rx_data",   bus.rx_data, '0);
    check("rst_rx_valid",  FB'(bus.rx_valid), FB'(0));
    check("rst_busy",      FB'(bus.busy), FB'(0));
    check("rst_done",      FB'(bus.done), FB'(0));
    check("rst_frame_err", FB'(bus.frame_err), FB'(0));
    check("rst_overrun",   FB'(bus.overrun), FB'(0));

    load_tx(FB'('hAD));
    xfer("t1", FB'('hFF), FB, -1, '0, -1);

    accept();
    load_tx(392'h69c4e0d86a7b0430d8cdb78070b4c55a);
    xfer("t2", 392'h00112233445566778899aabbccddeeff_000102030405060708090a0b0c0d0e0f, FB, -1, '0, -1);
    accept();

    load_tx(rand_frame());
    xfer("t3_short", rand_frame(), 100, -1, '0, -1);
    xfer("t3_empty", rand_frame(), 0, -1, '0, -1);

    fa = rand_frame(); fa[7:0] = 8'hA5;
    fb = rand_frame(); fb[7:0] = 8'h5A;
    xfer("t4_a", fa, FB, -1, '0, -1);
    xfer("t4_b", fb, FB, -1, '0, -1);

    accept();
    load_tx(FB'('hF0));
    xfer("t5_a", rand_frame(), FB, 50, FB'('h1), -1);
    accept();
    xfer("t5_b", rand_frame(), FB, -1, '0, -1);

    accept();
    xfer("t6_rst", rand_frame(), FB, -1, '0, 200);
    xfer("t6_next", rand_frame(), FB, -1, '0, -1);

    for (int n = 0; n < 2; n++) begin
      if ($urandom_range(0, 1) == 1) accept();
      if ($urandom_range(0, 1) == 1) load_tx(rand_frame());
      xfer("t7_rand", rand_frame(), FB, -1, '0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_frame_responder.md
Name: spi_frame_responder

Overview:
SPI mode-0 responder (slave end) that terminates fixed-length frames issued by the SPI master and hands them to the AES datapath. The frame is 392 bits: key, plaintext and header, MSB first. It shifts the inbound frame off mosi and shifts a response frame (AES result, zero-extended) onto miso in the same transaction. A valid/ready handshake connects it to the downstream AES core, and a load strobe connects it to the result path.

Parameters:
FRAME_BITS, 392, bits per SPI frame (mosi and miso).
SYNC_STAGES, 2, synchronizer flops on sclk/cs/mosi (min 2).

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
sclk  input  1  SPI clock from master; CPOL=0, asynchronous to clk.
cs  input  1  chip select, active low.
mosi  input  1  master-out data.
miso  output  1  slave-out data; 0 while cs high.
rx_data  output  FRAME_BITS  last complete received frame.
rx_valid  output  1  rx_data holds an unconsumed frame.
rx_ready  input  1  downstream accepts rx_data when rx_valid&&rx_ready.
tx_data  input  FRAME_BITS  response frame to send.
tx_load  input  1  1-cycle strobe: capture tx_data into tx_buf.
busy  output  1  frame in progress (synced cs low).
done  output  1  1-cycle pulse on complete frame.
frame_err  output  1  1-cycle pulse when cs rises with 0 < bit count < FRAME_BITS.
overrun  output  1  1-cycle pulse when a frame completes while rx_valid is still high.

Behaviour:
- Reset values: miso=0, rx_data=0, rx_valid=0, busy=0, done=0, frame_err=0, overrun=0. Internally tx_buf=0, bit_cnt=0, state=IDLE.
- sclk, cs and mosi each pass through SYNC_STAGES flops. Edges are detected on the synced sclk and cs.
- Timing constraint: sclk high and low phases each >= SYNC_STAGES+2 clk cycles. Edge-to-action latency is SYNC_STAGES+1 clk.
- Mode 0 rules:
  - Sample mosi on synced sclk rising.
  - Update miso on synced sclk falling.
  - The first miso bit is valid at the synced cs falling edge.
- FSM IDLE -> SHIFT -> IDLE.
- IDLE:
  - On synced cs fall: tx_shift<=tx_buf, miso<=tx_buf[FRAME_BITS-1], bit_cnt<=0, busy<=1, go to SHIFT.
- SHIFT:
  - sclk rise: rx_shift<={rx_shift[FRAME_BITS-2:0], mosi_s}, bit_cnt++.
  - sclk fall: tx_shift<<=1, miso<=next MSB.
  - When bit_cnt reaches FRAME_BITS on a rise:
    - rx_data<=assembled frame; rx_valid<=1; done pulses the next cycle.
    - If rx_valid was already 1, overrun pulses and the new frame overwrites.
  - Further sclk edges before cs rises are ignored: no shift, bit_cnt saturates.
  - Synced cs rise:
    - Go to IDLE, busy<=0, miso<=0.
    - If 0<bit_cnt<FRAME_BITS, frame_err pulses and rx_data/rx_valid are unchanged.
    - If bit_cnt==0, no flag.
- rx handshake:
  - rx_valid clears on the cycle after rx_valid&&rx_ready.
  - If a new frame completes in the same cycle as acceptance, rx_valid stays 1 with the new data, and no overrun is flagged.
- tx_load:
  - Writes tx_buf at any time.
  - The in-flight tx_shift is not affected; the new value is used from the next frame.
  - tx_buf persists across frames, so the last loaded value is resent.
- cs fall and cs rise in the same synced cycle cannot occur. A cs glitch shorter than SYNC_STAGES clk is undefined.
- Reset mid-frame: all state returns to reset values at once. The remainder of the frame is ignored until cs goes high and falls again, i.e. the FSM needs a fresh synced cs fall and does not resume on a cs that is already low.

Decomposition:
- Shared package spi_pkg:
  - FRAME_BITS_DEFAULT = 392.
  - Frame field offsets: header/key/plaintext MSB-LSB positions, matching master_full.
  - State enum values IDLE/SHIFT.
- Sub-module spi_sync_edge:
  - SYNC_STAGES-flop synchronizer on one input.
  - Outputs: level, rise pulse, fall pulse.
  - Instantiated for sclk and cs; mosi uses the level only.

Test Plan:
1. Reset, tx_load with tx_data=392'hAD, then the master sends 392'hFF -> rx_data==392'hFF, done pulses once, rx_valid=1. Master data_out==392'hAD.
2. Master sends 392'h00112233445566778899aabbccddeeff_000102030405060708090a0b0c0d0e0f, slave tx=392'h69c4e0d86a7b0430d8cdb78070b4c55a -> exact match both directions. Hold rx_ready=1 for one cycle -> rx_valid drops next cycle.
3. Drive cs low, 100 sclk pulses, then cs high -> frame_err pulses once, rx_valid and rx_data unchanged, busy back to 0.
4. Two back-to-back full frames (0x...A5, then 0x...5A) with rx_ready=0 -> overrun pulses once and rx_data==0x...5A.
5. tx_load 392'h1 at bit 50 of a frame carrying tx_buf=392'hF0 -> that frame returns 0xF0 and the next frame returns 0x1.
6. Assert reset at bit 200 with cs still low, release, then finish the master clocks -> no done and no rx_valid. The next full frame after cs toggles is received correctly.
